// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared multiplier/accumulator constants, state type and saturating add
package mult_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    // Operands in 32-bit containers; result is {overflow, clamped sum}. acc_w must be below 32.
    function automatic logic [32:0] sat_add(input logic [31:0] acc, input logic [31:0] prod,
                                            input int unsigned acc_w);
        logic [32:0] full;
        logic [32:0] lim;
        full = {1'b0, acc} + {1'b0, prod};
        lim  = (33'd1 << acc_w) - 33'd1;
        if (full > lim) begin
            return {1'b1, lim[31:0]};
        end
        return {1'b0, full[31:0]};
    endfunction

endpackage

// File: rtl/sat_adder.sv
// rtl/sat_adder.sv - combinational unsigned add of a product into an accumulator, clamped to all-ones
module sat_adder
    import mult_pkg::*;
#(
    parameter int DATA_W = mult_pkg::DATA_W,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [32:0] r;
    logic        unused_hi;

    assign r         = sat_add(32'(acc), 32'(prod), ACC_W);
    assign sum       = r[ACC_W-1:0];
    assign ovf       = r[32];
    assign unused_hi = ^r[31:ACC_W];

endmodule

// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - groups LEN accepted products into a saturating sum with a held valid/ready result
module prod_accum
    import mult_pkg::*;
#(
    parameter int DATA_W = mult_pkg::DATA_W,
    parameter int ACC_W  = 16,
    parameter int LEN    = 4,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              sum_sat,
    output logic [CNT_W-1:0]  cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    acc_state_t       state, state_next;
    logic [ACC_W-1:0] acc, acc_next, add_sum, sum_next;
    logic             flag, flag_next, add_ovf, sat_next, ov_next;
    logic [CNT_W-1:0] cnt_next;

    assign in_ready = (state == ACCUM) || out_ready;

    sat_adder #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_add (
        .acc  (acc),
        .prod (prod),
        .sum  (add_sum),
        .ovf  (add_ovf)
    );

    // acc is always zero in HOLD, so add_sum there is simply the new product.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        flag_next  = flag;
        cnt_next   = cnt;
        sum_next   = sum;
        sat_next   = sum_sat;
        ov_next    = out_valid;
        if (clear) begin
            state_next = ACCUM;
            acc_next   = '0;
            flag_next  = 1'b0;
            cnt_next   = '0;
            ov_next    = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (cnt == LAST) begin
                            sum_next   = add_sum;
                            sat_next   = flag | add_ovf;
                            ov_next    = 1'b1;
                            state_next = HOLD;
                            acc_next   = '0;
                            flag_next  = 1'b0;
                            cnt_next   = '0;
                        end else begin
                            acc_next  = add_sum;
                            flag_next = flag | add_ovf;
                            cnt_next  = cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (!in_valid) begin
                            ov_next    = 1'b0;
                            state_next = ACCUM;
                        end else if (LEN == 1) begin
                            sum_next = add_sum;
                            sat_next = 1'b0;
                        end else begin
                            ov_next    = 1'b0;
                            state_next = ACCUM;
                            acc_next   = add_sum;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                end
                default: state_next = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            flag      <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            sum_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            flag      <= flag_next;
            cnt       <= cnt_next;
            sum       <= sum_next;
            sum_sat   <= sat_next;
            out_valid <= ov_next;
        end
    end

endmodule
